// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_BYTE_W      = 8;
    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational rotate-priority picker: first eligible index strictly after ptr_i,
// wrapping modulo N_REQ, so the previous winner has the lowest priority.
module uart_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_onehot_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        win_onehot_o = '0;
        win_idx_o    = '0;
        any_o        = 1'b0;
        idx          = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (!any_o && eligible_i[idx]) begin
                any_o             = 1'b1;
                win_idx_o         = idx;
                win_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter byte channel among N_REQ requesters.
// Define UART_ARB_LOCK_EN to keep multi-byte messages (req_last framing) contiguous.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             grant,
    output logic [UART_BYTE_W-1:0]       tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic [1:0]                   dbg_state_o
);

    // Handshakes: a requester's byte is taken in the cycle req_ready[i] is high
    // (one-cycle pulse); the transmitter owns the byte once it drops tx_ready
    // while tx_valid is high, and tx_ready rising again means it can take another.

    uart_arb_state_t        state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   lock_q;
    logic                   lock_d;
    logic [N_REQ-1:0]       req_ready_q;
    logic [N_REQ-1:0]       grant_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic                   tx_valid_q;

    logic [N_REQ-1:0]       eligible;
    logic [N_REQ-1:0]       win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[UART_BYTE_W*i +: UART_BYTE_W];
        end
    end

`ifdef UART_ARB_LOCK_EN
    // While locked, grant_q still holds the message owner, so only it may win.
    assign eligible = lock_q ? (req_valid & grant_q) : req_valid;
    assign lock_d   = ~req_last[win_idx];
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign eligible        = req_valid;
    assign lock_d          = 1'b0;
`endif

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .eligible_i   (eligible),
        .ptr_i        (ptr_q),
        .win_onehot_o (win_onehot),
        .win_idx_o    (win_idx),
        .any_o        (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= IDX_W'(N_REQ - 1);
            lock_q      <= 1'b0;
            req_ready_q <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            req_ready_q <= '0;
            unique case (state_q)
                ARB: begin
                    if (win_any && tx_ready) begin
                        tx_data_q   <= req_bytes[win_idx];
                        grant_q     <= win_onehot;
                        req_ready_q <= win_onehot;
                        tx_valid_q  <= 1'b1;
                        ptr_q       <= win_idx;
                        lock_q      <= lock_d;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_ready) begin
                        state_q <= ARB;
                        if (!lock_q) begin
                            grant_q <= '0;
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q != ARB);
    assign dbg_state_o = state_q;

endmodule
